// File: rtl/ball_kinematics.sv
`default_nettype none
// ============================================================================
// Module   : ball_kinematics
// Desc     : Per-ball fixed-point 2-D motion integrator. Position advances by
//            velocity on each frame strobe while MOVING, friction shrinks the
//            velocity magnitude every FRICTION_PERIOD frames, velocity loads
//            saturate to +/-VEL_LIMIT, and position loads clear the fraction.
// Config   : define BALL_WALL_BOUNCE_EN to reflect the ball off the table
//            bounds (X_MIN..X_MAX, Y_MIN..Y_MAX) and pulse wallHit; without
//            it positions simply wrap and wallHit stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module ball_kinematics #(
  parameter int FRAC_BITS       = 6,
  parameter int POS_W           = 11,
  parameter int VEL_W           = 11,
  parameter int VEL_LIMIT       = 200,
  parameter int FRICTION_PERIOD = 5,
  parameter int FRICTION_STEP   = 1,
  parameter int INIT_X_POS      = 0,
  parameter int INIT_Y_POS      = 0,
  parameter int INIT_X_VEL      = 0,
  parameter int INIT_Y_VEL      = 0,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    velWrEn,
  input  logic signed [VEL_W-1:0] inVelX,
  input  logic signed [VEL_W-1:0] inVelY,
  input  logic                    posWrEn,
  input  logic [POS_W-1:0]        inPosX,
  input  logic [POS_W-1:0]        inPosY,
  output logic [POS_W-1:0]        topLeftPosX,
  output logic [POS_W-1:0]        topLeftPosY,
  output logic signed [VEL_W-1:0] outVelX,
  output logic signed [VEL_W-1:0] outVelY,
  output logic                    ballStopped,
  output logic                    frameDone,
  output logic                    wallHit
);

  // Internal position: sign bit + integer pixels + fraction.
  localparam int PW    = POS_W + FRAC_BITS + 1;
  localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(FRICTION_PERIOD - 1);
  localparam logic signed [VEL_W-1:0] VEL_LIM  = VEL_W'(VEL_LIMIT);
  localparam logic signed [VEL_W-1:0] FR_STEP  = VEL_W'(FRICTION_STEP);
  localparam logic signed [PW-1:0]    INIT_PX  = PW'(INIT_X_POS * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0]    INIT_PY  = PW'(INIT_Y_POS * (2 ** FRAC_BITS));
  localparam logic signed [VEL_W-1:0] INIT_VX  = VEL_W'(INIT_X_VEL);
  localparam logic signed [VEL_W-1:0] INIT_VY  = VEL_W'(INIT_Y_VEL);

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_MOVING  = 1'b1
  } state_t;

  localparam state_t INIT_STATE =
    ((INIT_X_VEL != 0) || (INIT_Y_VEL != 0)) ? ST_MOVING : ST_STOPPED;

`ifdef BALL_WALL_BOUNCE_EN
  // Fixed-point bounds; *_HI_EDGE is the first position whose integer part
  // exceeds the maximum pixel.
  localparam logic signed [PW-1:0] X_LO      = PW'(X_MIN * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0] X_HI      = PW'(X_MAX * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0] X_HI_EDGE = PW'((X_MAX + 1) * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0] Y_LO      = PW'(Y_MIN * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0] Y_HI      = PW'(Y_MAX * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0] Y_HI_EDGE = PW'((Y_MAX + 1) * (2 ** FRAC_BITS));
`else
  // Table bounds only matter for the bounce feature.
  logic unused_bounds;
  assign unused_bounds = ((X_MIN + X_MAX + Y_MIN + Y_MAX) != 0);
`endif

  state_t                  state, state_nxt;
  logic signed [PW-1:0]    pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic signed [PW-1:0]    sum_x, sum_y;
  logic signed [VEL_W-1:0] vel_x, vel_y, vel_x_nxt, vel_y_nxt;
  logic signed [VEL_W-1:0] sat_x, sat_y, fric_x, fric_y;
  logic [CNT_W-1:0]        fric_cnt, fric_cnt_nxt;
  logic                    done_q, done_nxt, hit_q, hit_nxt;
  logic                    frame_upd, fric_wrap;

  function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [VEL_W-1:0] v);
    if (v > VEL_LIM)       return VEL_LIM;
    else if (v < -VEL_LIM) return -VEL_LIM;
    else                   return v;
  endfunction

  // Magnitude reduction toward zero; never flips the sign.
  function automatic logic signed [VEL_W-1:0] friction(input logic signed [VEL_W-1:0] v);
    if (v > FR_STEP)       return v - FR_STEP;
    else if (v < -FR_STEP) return v + FR_STEP;
    else                   return '0;
  endfunction

  function automatic logic signed [PW-1:0] ext_vel(input logic signed [VEL_W-1:0] v);
    return {{(PW-VEL_W){v[VEL_W-1]}}, v};
  endfunction

  // Next-state computation: velocity load, frame update, bounce, position load.
  always_comb begin
    sat_x        = sat_vel(inVelX);
    sat_y        = sat_vel(inVelY);
    sum_x        = pos_x + ext_vel(vel_x);
    sum_y        = pos_y + ext_vel(vel_y);
    fric_wrap    = (fric_cnt == CNT_LAST);
    fric_x       = fric_wrap ? friction(vel_x) : vel_x;
    fric_y       = fric_wrap ? friction(vel_y) : vel_y;
    frame_upd    = (state == ST_MOVING) && startOfFrame && !velWrEn;

    state_nxt    = state;
    pos_x_nxt    = pos_x;
    pos_y_nxt    = pos_y;
    vel_x_nxt    = vel_x;
    vel_y_nxt    = vel_y;
    fric_cnt_nxt = fric_cnt;
    done_nxt     = 1'b0;
    hit_nxt      = 1'b0;

    if (velWrEn) begin
      vel_x_nxt = sat_x;
      vel_y_nxt = sat_y;
      if ((sat_x != '0) || (sat_y != '0)) begin
        state_nxt    = ST_MOVING;
        fric_cnt_nxt = '0;
      end else begin
        state_nxt    = ST_STOPPED;
      end
    end else if (frame_upd) begin
      fric_cnt_nxt = fric_wrap ? '0 : fric_cnt + CNT_W'(1);
      vel_x_nxt    = fric_x;
      vel_y_nxt    = fric_y;
      pos_x_nxt    = sum_x;
      pos_y_nxt    = sum_y;
`ifdef BALL_WALL_BOUNCE_EN
      // Reflection only follows a real position add, so a same-cycle
      // position load suppresses it.
      if (!posWrEn) begin
        if (sum_x < X_LO) begin
          pos_x_nxt = X_LO + X_LO - sum_x;
          vel_x_nxt = -fric_x;
          hit_nxt   = 1'b1;
        end else if (sum_x >= X_HI_EDGE) begin
          pos_x_nxt = X_HI + X_HI - sum_x;
          vel_x_nxt = -fric_x;
          hit_nxt   = 1'b1;
        end
        if (sum_y < Y_LO) begin
          pos_y_nxt = Y_LO + Y_LO - sum_y;
          vel_y_nxt = -fric_y;
          hit_nxt   = 1'b1;
        end else if (sum_y >= Y_HI_EDGE) begin
          pos_y_nxt = Y_HI + Y_HI - sum_y;
          vel_y_nxt = -fric_y;
          hit_nxt   = 1'b1;
        end
      end
`endif
      done_nxt = 1'b1;
      if ((fric_x == '0) && (fric_y == '0)) state_nxt = ST_STOPPED;
    end

    if (posWrEn) begin
      pos_x_nxt = {1'b0, inPosX, {FRAC_BITS{1'b0}}};
      pos_y_nxt = {1'b0, inPosY, {FRAC_BITS{1'b0}}};
    end
  end

  // State, position, velocity, friction counter and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT_STATE;
      pos_x    <= INIT_PX;
      pos_y    <= INIT_PY;
      vel_x    <= INIT_VX;
      vel_y    <= INIT_VY;
      fric_cnt <= '0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pos_x    <= pos_x_nxt;
      pos_y    <= pos_y_nxt;
      vel_x    <= vel_x_nxt;
      vel_y    <= vel_y_nxt;
      fric_cnt <= fric_cnt_nxt;
      done_q   <= done_nxt;
      hit_q    <= hit_nxt;
    end
  end

  assign topLeftPosX = pos_x[FRAC_BITS +: POS_W];
  assign topLeftPosY = pos_y[FRAC_BITS +: POS_W];
  assign outVelX     = vel_x;
  assign outVelY     = vel_y;
  assign ballStopped = (state == ST_STOPPED);
  assign frameDone   = done_q;
  assign wallHit     = hit_q;

endmodule
`default_nettype wire
